cordic_iter_ctrl: RTL and testbench

//  Sequencer for a single-stage iterative CORDIC rotator. Accepts one (x,y,z) sample via a

---
 rtl/cordic_iter_ctrl_if.sv | 27 ++
 rtl/cordic_iter_ctrl.sv | 154 +++++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_iter_ctrl_if.sv
// Sample and result channels of the iterative CORDIC sequencer.
// The slave side belongs to the rotator; the master side drives samples in
// and consumes rotated results.
interface cordic_iter_ctrl_if #(
  parameter int XY_WIDTH = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [XY_WIDTH-1:0] xin;
  logic signed [XY_WIDTH-1:0] yin;
  logic        [15:0]         zin;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [XY_WIDTH+1:0] xout;
  logic signed [XY_WIDTH+1:0] yout;
  logic signed [15:0]         zout;

  modport master (
    output in_valid, xin, yin, zin, out_ready,
    input  in_ready, out_valid, xout, yout, zout
  );

  modport slave (
    input  in_valid, xin, yin, zin, out_ready,
    output in_ready, out_valid, xout, yout, zout
  );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC rotator sequencer: one shared shift-add stage stepped
// through ITERATIONS micro-rotations per sample. The quadrant fold happens
// on accept so the residual angle starts within +/-90 degrees. The counter
// runs one step past the last rotation; that extra step copies the result
// to the output registers.
module cordic_iter_ctrl #(
  parameter int XY_WIDTH   = 16,
  parameter int ITERATIONS = 14
) (
  input  logic               clock,
  input  logic               reset,
  cordic_iter_ctrl_if.slave  bus,
  output logic               busy
);

  localparam int          W         = XY_WIDTH + 2;
  localparam logic [3:0]  LAST_STEP = 4'(ITERATIONS);

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  state_t              state_q, state_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d;
  logic signed [W-1:0] xout_q, xout_d, yout_q, yout_d;
  logic signed [15:0]  z_q, z_d, zout_q, zout_d;
  logic [3:0]          iter_q, iter_d;
  logic                out_valid_q, out_valid_d;

  logic                in_ready_w;
  logic                map_neg;
  logic signed [W-1:0] xin_ext, yin_ext;
  logic signed [W-1:0] x_shr, y_shr, x_rot, y_rot;
  logic signed [15:0]  z_rot;
  logic [15:0]         atan_val;

  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'd8192;
      4'd1:    atan_lut = 16'd4836;
      4'd2:    atan_lut = 16'd2555;
      4'd3:    atan_lut = 16'd1297;
      4'd4:    atan_lut = 16'd651;
      4'd5:    atan_lut = 16'd326;
      4'd6:    atan_lut = 16'd163;
      4'd7:    atan_lut = 16'd81;
      4'd8:    atan_lut = 16'd41;
      4'd9:    atan_lut = 16'd20;
      4'd10:   atan_lut = 16'd10;
      4'd11:   atan_lut = 16'd5;
      4'd12:   atan_lut = 16'd3;
      4'd13:   atan_lut = 16'd1;
      4'd14:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

  // Quadrant fold of the incoming sample and one micro-rotation of the held state
  always_comb begin
    map_neg  = bus.zin[15] ^ bus.zin[14];
    xin_ext  = {{2{bus.xin[XY_WIDTH-1]}}, bus.xin};
    yin_ext  = {{2{bus.yin[XY_WIDTH-1]}}, bus.yin};
    x_shr    = x_q >>> iter_q;
    y_shr    = y_q >>> iter_q;
    atan_val = atan_lut(iter_q);
    if (z_q[15]) begin
      x_rot = x_q + y_shr;
      y_rot = y_q - x_shr;
      z_rot = z_q + atan_val;
    end else begin
      x_rot = x_q - y_shr;
      y_rot = y_q + x_shr;
      z_rot = z_q - atan_val;
    end
  end

  assign in_ready_w = (state_q == IDLE) && !reset;

  // Sequencer: accept, rotate ITERATIONS times, publish, wait for the consumer
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    iter_d      = iter_q;
    xout_d      = xout_q;
    yout_d      = yout_q;
    zout_d      = zout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_w) begin
          x_d     = map_neg ? -xin_ext : xin_ext;
          y_d     = map_neg ? -yin_ext : yin_ext;
          z_d     = {bus.zin[14], bus.zin[14:0]};
          iter_d  = 4'd0;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        if (iter_q == LAST_STEP) begin
          xout_d      = x_q;
          yout_d      = y_q;
          zout_d      = z_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          x_d    = x_rot;
          y_d    = y_rot;
          z_d    = z_rot;
          iter_d = iter_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous clear
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      iter_q      <= '0;
      xout_q      <= '0;
      yout_q      <= '0;
      zout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      iter_q      <= iter_d;
      xout_q      <= xout_d;
      yout_q      <= yout_d;
      zout_q      <= zout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.xout      = xout_q;
  assign bus.yout      = yout_q;
  assign bus.zout      = zout_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for the iterative CORDIC sequencer.
module tb_cordic_iter_ctrl;

  localparam int ITER = 14;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   atan_tab [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                          41, 20, 10, 5, 3, 1, 1, 0};

  always #5 clock = ~clock;

  cordic_iter_ctrl_if #(.XY_WIDTH(16)) bus ();

  cordic_iter_ctrl #(.XY_WIDTH(16), .ITERATIONS(ITER)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference rotator built straight from the algorithm description
  task automatic golden(input logic signed [15:0] xi, input logic signed [15:0] yi,
                        input logic [15:0] zi, output logic signed [17:0] xo,
                        output logic signed [17:0] yo, output logic signed [15:0] zo);
    logic signed [17:0] x, y, xn, yn;
    logic signed [15:0] z;
    x = 18'(xi);
    y = 18'(yi);
    if (zi[15] ^ zi[14]) begin
      x = -x;
      y = -y;
    end
    z = {zi[14], zi[14:0]};
    for (int i = 0; i < ITER; i++) begin
      if (z < 0) begin
        xn = x + (y >>> i);
        yn = y - (x >>> i);
        z  = z + 16'(atan_tab[i]);
      end else begin
        xn = x - (y >>> i);
        yn = y + (x >>> i);
        z  = z - 16'(atan_tab[i]);
      end
      x = xn;
      y = yn;
    end
    xo = x;
    yo = y;
    zo = z;
  endtask

  // Offer one sample, measure accept-to-valid latency, then take the result
  task automatic run_sample(input logic signed [15:0] xi, input logic signed [15:0] yi,
                            input logic [15:0] zi, output int lat,
                            output logic signed [17:0] xo, output logic signed [17:0] yo,
                            output logic signed [15:0] zo);
    int guard;
    bus.xin      = xi;
    bus.yin      = yi;
    bus.zin      = zi;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    xo = bus.xout;
    yo = bus.yout;
    zo = bus.zout;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    bus.xin = 16'sd100;
    bus.yin = 16'sd0;
    bus.zin = 16'h0000;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid_busy: got out_valid=%b busy=%b expected 0/0", bus.out_valid, busy);
    end
    checks++;
    if (bus.xout !== 18'sd0 || bus.yout !== 18'sd0 || bus.zout !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %0d %0d %0d expected 0 0 0", bus.xout, bus.yout, bus.zout);
    end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_axis_zero;
    int lat;
    logic signed [17:0] xo, yo;
    logic signed [15:0] zo;
    run_sample(16'sd10000, 16'sd0, 16'h0000, lat, xo, yo, zo);
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("[TB] FAIL zero_latency: got %0d expected 15", lat);
    end
    checks++;
    if (xo !== 18'sd16470 || yo !== 18'sd1 || zo !== -16'sd1) begin
      errors++;
      $display("[TB] FAIL zero_result: got %0d %0d %0d expected 16470 1 -1", xo, yo, zo);
    end
  endtask

  task automatic test_quadrants;
    logic [15:0] zs [3] = '{16'h4000, 16'h8000, 16'hC000};
    int ex [3] = '{0, -16468, 0};
    int ey [3] = '{16468, 0, -16468};
    int lat;
    logic signed [17:0] xo, yo, gx, gy;
    logic signed [15:0] zo, gz;
    for (int q = 0; q < 3; q++) begin
      run_sample(16'sd10000, 16'sd0, zs[q], lat, xo, yo, zo);
      golden(16'sd10000, 16'sd0, zs[q], gx, gy, gz);
      checks++;
      if (lat !== 15 || (int'(xo) - ex[q]) > 4 || (int'(xo) - ex[q]) < -4 ||
          (int'(yo) - ey[q]) > 4 || (int'(yo) - ey[q]) < -4) begin
        errors++;
        $display("[TB] FAIL quadrant_%0h: got lat=%0d (%0d,%0d) expected lat=15 (%0d,%0d)+/-4",
                 zs[q], lat, xo, yo, ex[q], ey[q]);
      end
      checks++;
      if (xo !== gx || yo !== gy || zo !== gz) begin
        errors++;
        $display("[TB] FAIL quadrant_exact_%0h: got %0d %0d %0d expected %0d %0d %0d",
                 zs[q], xo, yo, zo, gx, gy, gz);
      end
    end
  endtask

  task automatic test_corner;
    int lat;
    logic signed [17:0] xo, yo, gx, gy;
    logic signed [15:0] zo, gz;
    run_sample(-16'sd32768, -16'sd32768, 16'h2000, lat, xo, yo, zo);
    golden(-16'sd32768, -16'sd32768, 16'h2000, gx, gy, gz);
    checks++;
    if (int'(xo) > 8 || int'(xo) < -8 || (int'(yo) + 76313) > 8 || (int'(yo) + 76313) < -8) begin
      errors++;
      $display("[TB] FAIL corner_range: got (%0d,%0d) expected (0,-76313)+/-8", xo, yo);
    end
    checks++;
    if (xo !== gx || yo !== gy || zo !== gz) begin
      errors++;
      $display("[TB] FAIL corner_exact: got %0d %0d %0d expected %0d %0d %0d", xo, yo, zo, gx, gy, gz);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int bad;
    logic signed [17:0] ax, ay, gx, gy, bx, by;
    logic signed [15:0] az, gz, bz;
    bus.xin = 16'sd3000;
    bus.yin = 16'sd4000;
    bus.zin = 16'h1000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rotate_busy: got busy=%b in_ready=%b expected 1/0", busy, bus.in_ready);
    end
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    golden(16'sd3000, 16'sd4000, 16'h1000, gx, gy, gz);
    ax = bus.xout;
    ay = bus.yout;
    az = bus.zout;
    checks++;
    if (lat !== 15 || ax !== gx || ay !== gy || az !== gz) begin
      errors++;
      $display("[TB] FAIL hold_first: got lat=%0d %0d %0d %0d expected lat=15 %0d %0d %0d",
               lat, ax, ay, az, gx, gy, gz);
    end
    bus.xin = -16'sd7000;
    bus.yin = 16'sd2500;
    bus.zin = 16'h5555;
    bus.in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b1 ||
          bus.xout !== ax || bus.yout !== ay || bus.zout !== az) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL hold_stable: got %0d unstable cycles expected 0", bad);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_idle: got out_valid=%b in_ready=%b busy=%b expected 0/1/0",
               bus.out_valid, bus.in_ready, busy);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL next_accept: got busy=%b in_ready=%b expected 1/0", busy, bus.in_ready);
    end
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    bx = bus.xout;
    by = bus.yout;
    bz = bus.zout;
    golden(-16'sd7000, 16'sd2500, 16'h5555, gx, gy, gz);
    checks++;
    if (lat !== 15 || bx !== gx || by !== gy || bz !== gz) begin
      errors++;
      $display("[TB] FAIL second_result: got lat=%0d %0d %0d %0d expected lat=15 %0d %0d %0d",
               lat, bx, by, bz, gx, gy, gz);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_abort;
    int lat;
    int seen;
    logic signed [17:0] xo, yo, gx, gy;
    logic signed [15:0] zo, gz;
    bus.xin = 16'sd12345;
    bus.yin = -16'sd2222;
    bus.zin = 16'h3333;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_in_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.xout !== 18'sd0 ||
        bus.yout !== 18'sd0 || bus.zout !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL abort_clear: got busy=%b valid=%b %0d %0d %0d expected 0 0 0 0 0",
               busy, bus.out_valid, bus.xout, bus.yout, bus.zout);
    end
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL abort_no_output: got %0d valid cycles expected 0", seen);
    end
    run_sample(-16'sd15000, 16'sd9000, 16'hA000, lat, xo, yo, zo);
    golden(-16'sd15000, 16'sd9000, 16'hA000, gx, gy, gz);
    checks++;
    if (lat !== 15 || xo !== gx || yo !== gy || zo !== gz) begin
      errors++;
      $display("[TB] FAIL abort_fresh: got lat=%0d %0d %0d %0d expected lat=15 %0d %0d %0d",
               lat, xo, yo, zo, gx, gy, gz);
    end
  endtask

  task automatic test_vectors;
    logic signed [15:0] vx [6] = '{16'sd1234, -16'sd20000, 16'sd32767, -16'sd1, 16'sd0, 16'sd32767};
    logic signed [15:0] vy [6] = '{-16'sd5678, 16'sd15000, 16'sd32767, 16'sd1, 16'sd0, -16'sd32768};
    logic [15:0]        vz [6] = '{16'h1234, 16'h9ABC, 16'h6000, 16'hFFFF, 16'h7FFF, 16'hE000};
    int lat;
    logic signed [17:0] xo, yo, gx, gy;
    logic signed [15:0] zo, gz;
    for (int v = 0; v < 6; v++) begin
      run_sample(vx[v], vy[v], vz[v], lat, xo, yo, zo);
      golden(vx[v], vy[v], vz[v], gx, gy, gz);
      checks++;
      if (lat !== 15 || xo !== gx || yo !== gy || zo !== gz) begin
        errors++;
        $display("[TB] FAIL vector_%0d: got lat=%0d %0d %0d %0d expected lat=15 %0d %0d %0d",
                 v, lat, xo, yo, zo, gx, gy, gz);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.xin = '0;
    bus.yin = '0;
    bus.zin = '0;
    test_reset();
    test_axis_zero();
    test_quadrants();
    test_corner();
    test_back_to_back();
    test_reset_abort();
    test_vectors();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
